// File: rtl/div_unit.sv
// div_unit: multicycle signed 32-bit restoring divider feeding hiDiv/loDiv.
// lo = quotient (truncated toward zero), hi = remainder (sign of dividend).
// start/busy/done handshake; div0 flags a zero divisor (1-cycle path).
// Optional build macro DIV_EARLY_EXIT_EN: when |dividend| < |divisor| the
// iteration phase is skipped (quotient 0, remainder |dividend|).
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t stateQ, stateD;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] absDvs;
  logic             signDvd;
  logic             signDvs;

  logic [WIDTH-1:0] absDvdIn;
  logic [WIDTH-1:0] absDvsIn;
  logic             divisorZero;
  logic             earlyExit;
  logic [WIDTH:0]   trial;

  // Operand magnitudes and trial subtraction for the current step.
  // rem[WIDTH-1] is always 0 during CALC (rem < |divisor| <= 2^(WIDTH-1)),
  // so using the full rem as the top bits equals the shifted-remainder form.
  always_comb begin
    absDvdIn    = dividend[WIDTH-1] ? -dividend : dividend;
    absDvsIn    = divisor[WIDTH-1]  ? -divisor  : divisor;
    divisorZero = (divisor == '0);
    trial       = {rem, quo[WIDTH-1]} - {1'b0, absDvs};
  end

`ifdef DIV_EARLY_EXIT_EN
  assign earlyExit = !divisorZero && (absDvdIn < absDvsIn);
`else
  assign earlyExit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: begin
        if (start) begin
          if (divisorZero)    stateD = DONE;
          else if (earlyExit) stateD = FIX;
          else                stateD = CALC;
        end
      end
      CALC:    if (cnt == '0) stateD = FIX;
      FIX:     stateD = DONE;
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Datapath and registered outputs; busy/done track the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      absDvs  <= '0;
      signDvd <= 1'b0;
      signDvs <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
    end else begin
      busy <= (stateD == CALC) || (stateD == FIX);
      done <= (stateD == DONE);
      case (stateQ)
        IDLE: begin
          if (start) begin
            signDvd <= dividend[WIDTH-1];
            signDvs <= divisor[WIDTH-1];
            absDvs  <= absDvsIn;
            div0    <= divisorZero;
            cnt     <= CNT_W'(WIDTH - 1);
            if (earlyExit) begin
              quo <= '0;
              rem <= absDvdIn;
            end else begin
              quo <= absDvdIn;
              rem <= '0;
            end
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          lo <= (signDvd ^ signDvs) ? -quo : quo;
          hi <= signDvd ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with hand-computed results.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

`ifdef DIV_EARLY_EXIT_EN
  localparam int EARLY_LAT  = 2;
  localparam int EARLY_BUSY = 1;
`else
  localparam int EARLY_LAT  = 34;
  localparam int EARLY_BUSY = 33;
`endif

  div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div0     (div0),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one start, watch 40 cycles, then check latency, busy span,
  // single done pulse and results. injectAt>0 re-pulses start at that cycle.
  task automatic runDiv(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expLo,
                        input logic [31:0] expHi, input logic expDiv0,
                        input int expLat, input int expBusy,
                        input int injectAt);
    int doneCycle;
    int donePulses;
    int busyCount;
    doneCycle  = 0;
    donePulses = 0;
    busyCount  = 0;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0000;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        donePulses++;
        if (doneCycle == 0) doneCycle = k;
      end
      if (busy) busyCount++;
      if (k == injectAt) begin
        start    = 1'b1;
        dividend = 32'h0000_1234;
        divisor  = 32'h0000_0005;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checkVal({tag, ".latency"}, doneCycle, expLat);
    checkVal({tag, ".donePulses"}, donePulses, 1);
    checkVal({tag, ".busyCycles"}, busyCount, expBusy);
    checkVal({tag, ".lo"}, lo, expLo);
    checkVal({tag, ".hi"}, hi, expHi);
    checkVal({tag, ".div0"}, {31'b0, div0}, {31'b0, expDiv0});
  endtask

  initial begin
    int doneSeen;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset.hi", hi, 32'h0);
    checkVal("reset.lo", lo, 32'h0);
    checkVal("reset.ctrl", {29'b0, busy, done, div0}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    runDiv("basic", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 34, 33, 0);
    runDiv("zero", 32'd5, 32'd0, 32'd3, 32'd1, 1'b1, 1, 0, 0);
    runDiv("after0", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 33, 0);
    runDiv("negDvd", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
           1'b0, 34, 33, 0);
    runDiv("negDvs", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001,
           1'b0, 34, 33, 0);
    runDiv("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,
           1'b0, 34, 33, 10);

    // Abort mid-division with reset, then confirm no done follows.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checkVal("abort.busyBefore", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    checkVal("abort.hi", hi, 32'h0);
    checkVal("abort.lo", lo, 32'h0);
    checkVal("abort.ctrl", {29'b0, busy, done, div0}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b1;
    doneSeen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) doneSeen++;
    end
    checkVal("abort.noDone", doneSeen, 0);
    runDiv("restart", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 33, 0);

    runDiv("small", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, EARLY_LAT,
           EARLY_BUSY, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit divider that produces the `div` results captured by the HI/LO division registers (`hiDiv`/`loDiv`) of the MIPS datapath.
- Driven by the control unit through a start/busy/done handshake. Operands come from the A and B registers.
- Raises a divide-by-zero flag that the control unit uses to enter the exception sequence.

Parameters:
- WIDTH, 32, operand and result width in bits. Only 32 is supported for the MIPS core; other values are untested.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is synchronous to clk.
- start  input  1  request pulse, sampled only in IDLE.
- dividend  input  WIDTH  signed dividend (register A).
- divisor  input  WIDTH  signed divisor (register B).
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; hi/lo/div0 are valid from this cycle on.
- div0  output  1  divide-by-zero flag.
- hi  output  WIDTH  remainder, feeds hiDiv.
- lo  output  WIDTH  quotient, feeds loDiv.

Behaviour:
- Reset values (while reset=0):
  - state=IDLE, counter=0.
  - hi=0, lo=0, busy=0, done=0, div0=0.
  - Internal remainder, quotient and sign registers = 0.
- States: IDLE, CALC, FIX, DONE. All outputs are registered.
- IDLE:
  - start=1 in cycle T → latch sign bits and magnitudes of both operands (two's-complement negate when negative; |0x80000000| = 0x80000000 as unsigned). Clear div0.
  - If divisor==0: go to DONE. div0=1 and done=1 at T+1; hi/lo keep their previous values.
  - Else: remainder=0, counter=WIDTH-1, go to CALC.
- CALC: restoring division, one quotient bit per cycle, MSB first.
  - trial = {rem[WIDTH-2:0], qbit} − |divisor|, computed WIDTH+1 bits wide.
  - trial non-negative → rem=trial and shift in 1; otherwise shift the unchanged value and 0.
  - 32 cycles (T+1..T+32). When counter==0, go to FIX.
- FIX (T+33):
  - lo = quotient, negated if the dividend sign XOR divisor sign is 1 (truncation toward zero).
  - hi = remainder, negated if the dividend was negative (remainder takes the dividend's sign).
- DONE (T+34): done=1 for exactly one cycle, then IDLE.
- busy:
  - Normal path: 1 from T+1 through T+33, 0 in DONE and IDLE.
  - Zero-divisor path: busy stays 0.
- Total latency start→done: 34 cycles normal, 1 cycle divide-by-zero.
- start is ignored in CALC, FIX and DONE; dividend/divisor may change freely after T.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, div0=0 (natural wrap, no flag).
- div0 holds until the next accepted start or reset.
- hi/lo change only in FIX and hold otherwise, including across later div0 events.
- reset asserted mid-operation: immediate return to IDLE with all outputs 0. No done pulse for the aborted division.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in IDLE, with a non-zero divisor and |dividend| < |divisor| (unsigned magnitude compare):
  - Skip CALC; go directly to FIX with quotient=0 and remainder=|dividend|.
  - FIX at T+1, done at T+2; busy=1 only in T+1.
  - Results are identical to the full path.
- Undefined: every non-zero-divisor division takes the full 34 cycles regardless of operands.

Test Plan:
- Basic: reset released; dividend=7, divisor=2, start pulse at T → busy high T+1..T+33, done at T+34, lo=0x00000003, hi=0x00000001, div0=0.
- Signed: dividend=0xFFFFFFF9 (−7), divisor=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Then 7 / 0xFFFFFFFE (−2) → lo=0xFFFFFFFD, hi=0x00000001.
- Divide-by-zero: after the basic test, dividend=5, divisor=0 → div0=1 and done=1 at T+1, busy never high, hi=1 and lo=3 retained. A following 9/3 clears div0 and gives lo=3, hi=0.
- Overflow and ignored start:
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div0=0.
  - Pulse start again at T+10 with different operands → ignored: done only at T+34 with the original result, and no second done pulse.
- Reset mid-operation: start 100/7, drive reset=0 at T+15 for 2 cycles → hi=lo=0, busy=done=0 immediately; no done follows. A new 100/7 yields lo=14, hi=2 at T'+34.
- Early exit (DIV_EARLY_EXIT_EN defined): 3/10 → done at T+2, lo=0, hi=3. With the macro undefined, the same operands give done at T+34 with the same values.
